// File: rtl/key_debounce_multi.sv
// Multi-key debouncer: per-key synchroniser, filter FSM and press/release/long-press pulses.
// Define KEY_REPEAT_EN to re-issue key_press every T_RPT cycles once a hold has gone long.
module key_debounce_multi #(
    parameter int KEY_W  = 4,
    parameter int CNT_W  = 20,
    parameter int T_DEB  = 1_000_000,
    parameter int HOLD_W = 26,
    parameter int T_LONG = 50_000_000,
    parameter int T_RPT  = 10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_level,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_long
);

    typedef enum logic [1:0] {IDLE, PDEB, HELD, RDEB} key_state_e;

    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(T_DEB - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(T_LONG - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(T_RPT - 1);
`endif

    // Counters must cover their thresholds, otherwise a comparison could never match.
    if (T_DEB < 1 || (64'd1 << CNT_W) < 64'(T_DEB)) begin : g_bad_deb
        $error("key_debounce_multi: CNT_W too small for T_DEB");
    end
    if (T_LONG < 1 || T_RPT < 1 ||
        (64'd1 << HOLD_W) < 64'(T_LONG) || (64'd1 << HOLD_W) < 64'(T_RPT)) begin : g_bad_hold
        $error("key_debounce_multi: HOLD_W too small for T_LONG/T_RPT");
    end

    logic [KEY_W-1:0] sync1_q, sync1_d;
    logic [KEY_W-1:0] syn_q, syn_d;

    always_comb begin
        sync1_d = key_in;
        syn_d   = sync1_q;
    end

    // Sync flops reset to released so a held key is re-debounced after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            syn_q   <= '1;
        end else begin
            sync1_q <= sync1_d;
            syn_q   <= syn_d;
        end
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        key_state_e        state_q, state_d;
        logic [CNT_W-1:0]  deb_cnt_q, deb_cnt_d;
        logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
        logic              long_done_q, long_done_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              release_q, release_d;
        logic              long_q, long_d;
        logic              syn;
        logic              hold_sat;
`ifdef KEY_REPEAT_EN
        logic [HOLD_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

        assign syn      = syn_q[i];
        assign hold_sat = (hold_cnt_q == LONG_LAST);

        always_comb begin
            state_d     = state_q;
            deb_cnt_d   = deb_cnt_q;
            hold_cnt_d  = hold_cnt_q;
            long_done_d = long_done_q;
            level_d     = level_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            long_d      = 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_cnt_d   = rpt_cnt_q;
`endif
            case (state_q)
                IDLE: begin
                    if (!syn) begin
                        state_d   = PDEB;
                        deb_cnt_d = '0;
                    end
                end
                PDEB: begin
                    if (syn) begin
                        state_d   = IDLE;
                        deb_cnt_d = '0;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_d     = HELD;
                        deb_cnt_d   = '0;
                        level_d     = 1'b1;
                        press_d     = 1'b1;
                        hold_cnt_d  = '0;
                        long_done_d = 1'b0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!hold_sat) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end else if (!long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                    if (syn) begin
                        state_d   = RDEB;
                        deb_cnt_d = '0;
                    end
                end
                RDEB: begin
                    if (!hold_sat) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                    if (!syn) begin
                        state_d   = HELD;
                        deb_cnt_d = '0;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_d     = IDLE;
                        deb_cnt_d   = '0;
                        level_d     = 1'b0;
                        release_d   = 1'b1;
                        hold_cnt_d  = '0;
                        long_done_d = 1'b0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end
            endcase
`ifdef KEY_REPEAT_EN
            // Repeat phase restarts from zero on the key_long cycle; never pulse on release.
            if ((state_q == HELD || state_q == RDEB) && long_done_q) begin
                rpt_cnt_d = (rpt_cnt_q == RPT_LAST) ? '0 : rpt_cnt_q + 1'b1;
                if (rpt_cnt_q == RPT_LAST && !release_d) begin
                    press_d = 1'b1;
                end
            end
            if (long_d || release_d) begin
                rpt_cnt_d = '0;
            end
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q     <= IDLE;
                deb_cnt_q   <= '0;
                hold_cnt_q  <= '0;
                long_done_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
                rpt_cnt_q   <= '0;
`endif
            end else begin
                state_q     <= state_d;
                deb_cnt_q   <= deb_cnt_d;
                hold_cnt_q  <= hold_cnt_d;
                long_done_q <= long_done_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                long_q      <= long_d;
`ifdef KEY_REPEAT_EN
                rpt_cnt_q   <= rpt_cnt_d;
`endif
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Testbench for key_debounce_multi: hand vectors, async reset, repeat behaviour and random
// key activity compared every cycle against a run-length based reference model.
module tb_key_debounce_multi;

    localparam int KW    = 4;
    localparam int TDEB  = 8;
    localparam int TLONG = 40;
    localparam int TRPT  = 10;
`ifdef KEY_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [KW-1:0] key_in;
    logic [KW-1:0] key_level;
    logic [KW-1:0] key_press;
    logic [KW-1:0] key_release;
    logic [KW-1:0] key_long;

    int errors = 0;
    int checks = 0;
    int longSeen2 = 0;

    key_debounce_multi #(
        .KEY_W (KW),
        .CNT_W (4),
        .T_DEB (TDEB),
        .HOLD_W(6),
        .T_LONG(TLONG),
        .T_RPT (TRPT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a key flips its level once the synchronised pin has shown the
    // opposite value for TDEB+1 consecutive samples; long/repeat are timed from the press.
    bit mS1[KW], mS2[KW], mRunVal[KW], mPrevSyn[KW], mLevel[KW], mLongDone[KW];
    int mRun[KW], mHeldFor[KW], mSinceLong[KW];
    logic [KW-1:0] expLevel, expPress, expRel, expLong;

    function automatic void modelReset();
        for (int i = 0; i < KW; i++) begin
            mS1[i] = 1'b1; mS2[i] = 1'b1; mRunVal[i] = 1'b1; mRun[i] = 0;
            mPrevSyn[i] = 1'b1; mLevel[i] = 1'b0; mLongDone[i] = 1'b0;
            mHeldFor[i] = 0; mSinceLong[i] = 0;
        end
        expLevel = '0; expPress = '0; expRel = '0; expLong = '0;
    endfunction

    function automatic void modelEdge(input logic [KW-1:0] kin);
        expPress = '0; expRel = '0; expLong = '0;
        for (int i = 0; i < KW; i++) begin
            bit s;
            s = mS2[i];
            mS2[i] = mS1[i];
            mS1[i] = kin[i];
            if (s == mRunVal[i]) mRun[i]++;
            else begin mRunVal[i] = s; mRun[i] = 1; end
            if (!mLevel[i]) begin
                if (!s && mRun[i] == TDEB + 1) begin
                    mLevel[i] = 1'b1; expPress[i] = 1'b1;
                    mHeldFor[i] = 0; mLongDone[i] = 1'b0; mSinceLong[i] = 0;
                end
            end else begin
                mHeldFor[i]++;
                if (s && mRun[i] == TDEB + 1) begin
                    mLevel[i] = 1'b0; expRel[i] = 1'b1;
                end else begin
                    if (RPT_ON && mLongDone[i]) begin
                        mSinceLong[i]++;
                        if (mSinceLong[i] % TRPT == 0) expPress[i] = 1'b1;
                    end
                    if (!mPrevSyn[i] && !mLongDone[i] && mHeldFor[i] >= TLONG) begin
                        expLong[i] = 1'b1; mLongDone[i] = 1'b1; mSinceLong[i] = 0;
                    end
                end
            end
            mPrevSyn[i] = s;
            expLevel[i] = mLevel[i];
        end
    endfunction

    task automatic checkOutput(input string name, input logic [KW-1:0] el, input logic [KW-1:0] ep,
                               input logic [KW-1:0] er, input logic [KW-1:0] eg);
        checks++;
        if (key_level !== el || key_press !== ep || key_release !== er || key_long !== eg) begin
            errors++;
            $display("[TB] FAIL %s t=%0t level=%b/%b press=%b/%b release=%b/%b long=%b/%b (actual/required)",
                     name, $time, key_level, el, key_press, ep, key_release, er, key_long, eg);
        end
    endtask

    // One clock: model the edge with the inputs present at it, then compare against the model.
    task automatic tick();
        @(posedge clk);
        #1;
        modelEdge(key_in);
        if (key_long[2]) longSeen2++;
        checkOutput("model", expLevel, expPress, expRel, expLong);
    endtask

    task automatic applyStimulus(input logic [KW-1:0] k, input int n);
        key_in = k;
        repeat (n) tick();
    endtask

    typedef struct {
        string         name;
        logic [KW-1:0] keyIn;
        int            n;
        logic [KW-1:0] level;
        logic [KW-1:0] press;
        logic [KW-1:0] rel;
        logic [KW-1:0] lng;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [KW-1:0] rptP2, rptP4;
        rptP2 = RPT_ON ? 4'h2 : 4'h0;
        rptP4 = RPT_ON ? 4'h4 : 4'h0;

        vecs.push_back('{"k0_pre",       4'hE, 10, 4'h0, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{"k0_press",     4'hE,  1, 4'h1, 4'h1, 4'h0, 4'h0});
        vecs.push_back('{"k0_after",     4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{"k0_relwait",   4'hF, 10, 4'h1, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{"k0_release",   4'hF,  1, 4'h0, 4'h0, 4'h1, 4'h0});
        vecs.push_back('{"k0_idle",      4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{"k1_bounce_a",  4'hD,  5, 4'h0, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{"k1_bounce_b",  4'hF,  2, 4'h0, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{"k1_bounce_c",  4'hD,  5, 4'h0, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{"k1_bounce_d",  4'hF, 20, 4'h0, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{"k03_press",    4'h6, 11, 4'h9, 4'h9, 4'h0, 4'h0});
        vecs.push_back('{"k0_rel_first", 4'h7,  3, 4'h9, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{"k0_release2",  4'hF,  8, 4'h8, 4'h0, 4'h1, 4'h0});
        vecs.push_back('{"k3_release",   4'hF,  3, 4'h0, 4'h0, 4'h8, 4'h0});
        vecs.push_back('{"idle2",        4'hF,  5, 4'h0, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{"k2_press",     4'hB, 11, 4'h4, 4'h4, 4'h0, 4'h0});
        vecs.push_back('{"k2_prelong",   4'hB, 39, 4'h4, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{"k2_long",      4'hB,  1, 4'h4, 4'h0, 4'h0, 4'h4});
        vecs.push_back('{"k2_hold",      4'hB, 19, 4'h4, 4'h0, 4'h0, 4'h0});
        vecs.push_back('{"k2_hold_end",  4'hB,  1, 4'h4, rptP4, 4'h0, 4'h0});
        vecs.push_back('{"k2_relwait",   4'hF, 10, 4'h4, rptP4, 4'h0, 4'h0});
        vecs.push_back('{"k2_release",   4'hF,  1, 4'h0, 4'h0, 4'h4, 4'h0});

        rst_n  = 1'b0;
        key_in = 4'hF;
        modelReset();
        #3;
        checkOutput("reset_state", 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'hF, 20);

        $display("[TB] table vectors");
        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].name == "k2_press") longSeen2 = 0;
            applyStimulus(vecs[v].keyIn, vecs[v].n);
            checkOutput(vecs[v].name, vecs[v].level, vecs[v].press, vecs[v].rel, vecs[v].lng);
        end
        checks++;
        if (longSeen2 != 1) begin
            errors++;
            $display("[TB] FAIL k2_long_once count=%0d required=1", longSeen2);
        end

        $display("[TB] async reset while held");
        applyStimulus(4'hE, 11);
        checkOutput("rst_pre_press", 4'h1, 4'h1, 4'h0, 4'h0);
        applyStimulus(4'hE, 5);
        checkOutput("rst_pre_held", 4'h1, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_clear", 4'h0, 4'h0, 4'h0, 4'h0);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        checkOutput("rst_repress_wait", 4'h0, 4'h0, 4'h0, 4'h0);
        tick();
        checkOutput("rst_repress", 4'h1, 4'h1, 4'h0, 4'h0);
        applyStimulus(4'hF, 12);
        checkOutput("rst_released", 4'h0, 4'h0, 4'h0, 4'h0);

        $display("[TB] long hold and repeat on key 1");
        applyStimulus(4'hD, 11);
        checkOutput("k1_press", 4'h2, 4'h2, 4'h0, 4'h0);
        applyStimulus(4'hD, 40);
        checkOutput("k1_long", 4'h2, 4'h0, 4'h0, 4'h2);
        applyStimulus(4'hD, 10);
        checkOutput("k1_repeat1", 4'h2, rptP2, 4'h0, 4'h0);
        applyStimulus(4'hD, 10);
        checkOutput("k1_repeat2", 4'h2, rptP2, 4'h0, 4'h0);
        applyStimulus(4'hF, 12);
        checkOutput("k1_released", 4'h0, 4'h0, 4'h0, 4'h0);

        $display("[TB] random key activity");
        for (int seg = 0; seg < 60; seg++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom_range(1, 60));
        end
        applyStimulus(4'hF, 15);
        checkOutput("final_idle", 4'h0, 4'h0, 4'h0, 4'h0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
